// File: rtl/tbb_fetch.sv
// tbb_fetch: turns task batch buffer line requests into host reads
// and writes returning lines into the buffer by response tag.
module tbb_fetch #(
  parameter int TBB_WR_ADDR_WIDTH = 12,
  parameter int TBB_WR_DATA_WIDTH = 512,
  parameter int HOST_ADDR_WIDTH   = 32,
  parameter int BATCH_CNT_WIDTH   = 16,
  parameter int MAX_OUTSTANDING   = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cfg_start,
  input  logic [HOST_ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic [BATCH_CNT_WIDTH-1:0]   cfg_num_batches,
  input  logic                         ReqValid,
  input  logic [TBB_WR_ADDR_WIDTH-1:0] ReqLineIdx,
  output logic                         ReqAck,
  input  logic                         tx_almost_full,
  output logic                         rd_req_valid,
  output logic [HOST_ADDR_WIDTH-1:0]   rd_req_addr,
  output logic [TBB_WR_ADDR_WIDTH-1:0] rd_req_tag,
  input  logic                         rd_rsp_valid,
  input  logic [TBB_WR_ADDR_WIDTH-1:0] rd_rsp_tag,
  input  logic [TBB_WR_DATA_WIDTH-1:0] rd_rsp_data,
  output logic                         WrEn,
  output logic [TBB_WR_ADDR_WIDTH-1:0] WrAddr,
  output logic [TBB_WR_DATA_WIDTH-1:0] WrDin,
  output logic                         busy,
  output logic                         done
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = BATCH_CNT_WIDTH + TBB_WR_ADDR_WIDTH;
  localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);
  localparam logic [TBB_WR_ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_FETCH = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t                       state_q;
  logic [OW-1:0]                out_q, out_d;
  logic [BATCH_CNT_WIDTH-1:0]   batch_q, nb_q;
  logic [HOST_ADDR_WIDTH-1:0]   base_q, addr_d;
  logic [CW-1:0]                off;
  logic                         ack, last_line;

  assign ack = state_q[1] && ReqValid && !tx_almost_full
            && (out_q < MAXO);
  assign ReqAck = ack;
  assign last_line = (ReqLineIdx == LAST);

  // batch * lines_per_batch + line is just the concatenation
  assign off = {batch_q, ReqLineIdx};
  assign addr_d = base_q + HOST_ADDR_WIDTH'(off);

  // clamped at zero so responses from an aborted run are harmless
  always_comb begin
    out_d = out_q;
    if (ack && !rd_rsp_valid)
      out_d = out_q + 1'b1;
    else if (!ack && rd_rsp_valid && out_q != '0)
      out_d = out_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_tag   <= '0;
      WrEn         <= 1'b0;
      WrAddr       <= '0;
      WrDin        <= '0;
      out_q        <= '0;
      batch_q      <= '0;
      nb_q         <= '0;
      base_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rd_req_valid <= ack;
      if (ack) begin
        rd_req_addr <= addr_d;
        rd_req_tag  <= ReqLineIdx;
      end
      WrEn <= rd_rsp_valid;
      if (rd_rsp_valid) begin
        WrAddr <= rd_rsp_tag;
        WrDin  <= rd_rsp_data;
      end
      out_q <= out_d;
      unique case (1'b1)
        state_q[0]: begin
          if (cfg_start) begin
            base_q  <= cfg_base_addr;
            nb_q    <= cfg_num_batches;
            batch_q <= '0;
            if (cfg_num_batches != '0) begin
              state_q <= S_FETCH;
              busy    <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end
          end
        end
        state_q[1]: begin
          if (ack && last_line) begin
            batch_q <= batch_q + 1'b1;
            if (batch_q == nb_q - 1'b1)
              state_q <= S_DRAIN;
          end
        end
        state_q[2]: begin
          if (out_q == '0 && !rd_rsp_valid) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        state_q[3]: begin
          state_q <= S_IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbb_fetch.sv
// tb_tbb_fetch: randomized host/buffer stimulus with a queue-based
// scoreboard for host requests and buffer writes.
module tb_tbb_fetch;

  localparam int W  = 2;
  localparam int D  = 64;
  localparam int H  = 32;
  localparam int B  = 16;
  localparam int MO = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_start;
  logic [H-1:0] cfg_base_addr;
  logic [B-1:0] cfg_num_batches;
  logic         ReqValid;
  logic [W-1:0] ReqLineIdx;
  logic         ReqAck;
  logic         tx_almost_full;
  logic         rd_req_valid;
  logic [H-1:0] rd_req_addr;
  logic [W-1:0] rd_req_tag;
  logic         rd_rsp_valid;
  logic [W-1:0] rd_rsp_tag;
  logic [D-1:0] rd_rsp_data;
  logic         WrEn;
  logic [W-1:0] WrAddr;
  logic [D-1:0] WrDin;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  tbb_fetch #(
    .TBB_WR_ADDR_WIDTH(W),
    .TBB_WR_DATA_WIDTH(D),
    .HOST_ADDR_WIDTH(H),
    .BATCH_CNT_WIDTH(B),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_start(cfg_start),
    .cfg_base_addr(cfg_base_addr),
    .cfg_num_batches(cfg_num_batches),
    .ReqValid(ReqValid),
    .ReqLineIdx(ReqLineIdx),
    .ReqAck(ReqAck),
    .tx_almost_full(tx_almost_full),
    .rd_req_valid(rd_req_valid),
    .rd_req_addr(rd_req_addr),
    .rd_req_tag(rd_req_tag),
    .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_tag(rd_rsp_tag),
    .rd_rsp_data(rd_rsp_data),
    .WrEn(WrEn),
    .WrAddr(WrAddr),
    .WrDin(WrDin),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    longint       due;
    logic [H-1:0] addr;
    logic [W-1:0] tag;
  } req_t;
  typedef struct {
    longint       due;
    logic [W-1:0] tag;
    logic [D-1:0] data;
  } wr_t;
  typedef struct {
    longint       ready;
    logic [W-1:0] tag;
  } pend_t;

  req_t  rq[$];
  wr_t   wq[$];
  pend_t pq[$];

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  bit     mon_en = 1'b0;

  // model: 0 idle, 1 fetch, 2 drain, 3 done
  int           ms = 0;
  logic [H-1:0] m_base = '0;
  int           m_nb = 0;
  int           m_batch = 0;
  int           m_out = 0;
  int           m_idx = 0;

  int p_rv = 100;
  int p_taf = 0;
  bit taf_force = 1'b0;
  bit hold = 1'b0;
  int dmin = 3;
  int dmax = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // monitor: pops expected host requests and buffer writes when due
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        chk("rd_req_valid", longint'(rd_req_valid), 1);
        chk("rd_req_addr", longint'(rd_req_addr), longint'(rq[0].addr));
        chk("rd_req_tag", longint'(rd_req_tag), longint'(rq[0].tag));
        void'(rq.pop_front());
      end else begin
        chk("rd_req_quiet", longint'(rd_req_valid), 0);
      end
      if (wq.size() > 0 && wq[0].due == cyc) begin
        chk("WrEn", longint'(WrEn), 1);
        chk("WrAddr", longint'(WrAddr), longint'(wq[0].tag));
        chk("WrDin", longint'(WrDin), longint'(wq[0].data));
        void'(wq.pop_front());
      end else begin
        chk("WrEn_quiet", longint'(WrEn), 0);
      end
    end
  end

  task automatic step(bit st, logic [H-1:0] base, int nb, bit rst);
    bit          exp_ack;
    bit          found;
    int          j;
    int          n;
    int          nxt;
    logic [63:0] a;
    @(negedge clk);
    reset_n         = !rst;
    cfg_start       = st;
    cfg_base_addr   = base;
    cfg_num_batches = B'(nb);
    ReqValid        = ($urandom_range(99) < p_rv);
    ReqLineIdx      = ReqValid ? W'(m_idx) : W'($urandom);
    tx_almost_full  = taf_force || ($urandom_range(99) < p_taf);
    rd_rsp_valid    = 1'b0;
    rd_rsp_tag      = W'($urandom);
    rd_rsp_data     = {$urandom, $urandom};
    if (!hold && !rst && pq.size() > 0) begin
      found = 1'b0;
      j = $urandom_range(pq.size() - 1);
      for (int k = 0; k < pq.size(); k++) begin
        n = (j + k) % pq.size();
        if (!found && pq[n].ready <= cyc) begin
          found        = 1'b1;
          rd_rsp_valid = 1'b1;
          rd_rsp_tag   = pq[n].tag;
          pq.delete(n);
        end
      end
    end
    #1;
    exp_ack = (ms == 1) && ReqValid && !tx_almost_full && (m_out < MO);
    if (mon_en) begin
      chk("busy", longint'(busy), longint'(ms == 1 || ms == 2));
      chk("done", longint'(done), longint'(ms == 3));
      chk("ReqAck", longint'(ReqAck), longint'(exp_ack));
    end
    if (rst) begin
      ms = 0; m_out = 0; m_batch = 0; m_idx = 0;
    end else begin
      if (rd_rsp_valid)
        wq.push_back('{cyc + 1, rd_rsp_tag, rd_rsp_data});
      if (exp_ack) begin
        a = {32'd0, m_base} + (64'(m_batch) << W) + 64'(ReqLineIdx);
        rq.push_back('{cyc + 1, a[H-1:0], ReqLineIdx});
        pq.push_back('{cyc + 1 + $urandom_range(dmax, dmin),
                       ReqLineIdx});
      end
      nxt = ms;
      case (ms)
        0: if (st) begin
          m_base = base; m_nb = nb; m_batch = 0; m_idx = 0;
          nxt = (nb != 0) ? 1 : 3;
        end
        1: if (exp_ack) begin
          if (m_idx == (1 << W) - 1) begin
            if (m_batch == m_nb - 1) nxt = 2;
            m_batch++;
          end
          m_idx = (m_idx + 1) % (1 << W);
        end
        2: if (m_out == 0 && !rd_rsp_valid) nxt = 3;
        default: nxt = 0;
      endcase
      m_out = m_out + int'(exp_ack) - int'(rd_rsp_valid);
      if (m_out < 0) m_out = 0;
      ms = nxt;
    end
  endtask

  task automatic wait_idle(int bound, bit noise);
    int k = 0;
    while ((ms != 0 || rq.size() > 0 || wq.size() > 0 || pq.size() > 0)
           && k < bound) begin
      step(noise && ms != 0 && $urandom_range(49) == 0,
           $urandom, $urandom_range(3), 0);
      k++;
    end
    if (k >= bound) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: still busy after %0d cycles, want idle",
               bound);
    end
  endtask

  task automatic run(logic [H-1:0] base, int nb, bit noise);
    step(1, base, nb, 0);
    wait_idle(3000, noise);
  endtask

  initial begin
    reset_n = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0;
    cfg_num_batches = '0; ReqValid = 1'b0; ReqLineIdx = '0;
    tx_almost_full = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_tag = '0;
    rd_rsp_data = '0;
    repeat (2) step(0, 0, 0, 1);
    mon_en = 1'b1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_req_valid", longint'(rd_req_valid), 0);
    chk("rst_req_addr", longint'(rd_req_addr), 0);
    chk("rst_req_tag", longint'(rd_req_tag), 0);
    chk("rst_wren", longint'(WrEn), 0);
    chk("rst_wraddr", longint'(WrAddr), 0);
    chk("rst_wrdin", longint'(WrDin), 0);
    step(0, 0, 0, 0);

    // two batches, fixed 3-cycle echo
    run(32'h100, 2, 0);

    // outstanding limit with responses withheld
    hold = 1'b1;
    step(1, 32'h200, 1, 0);
    repeat (6) step(0, 0, 0, 0);
    hold = 1'b0;
    wait_idle(500, 0);

    // back-pressure window
    step(1, 32'h300, 1, 0);
    step(0, 0, 0, 0);
    taf_force = 1'b1;
    repeat (5) step(0, 0, 0, 0);
    taf_force = 1'b0;
    wait_idle(500, 0);

    // out-of-order responses
    dmin = 2; dmax = 8;
    run(32'h400, 1, 0);

    // empty run
    run(32'h500, 0, 0);

    // reset with two reads in flight, then wrap-around addresses
    hold = 1'b1;
    step(1, 32'h600, 2, 0);
    for (int k = 0; k < 20 && m_out < 2; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    hold = 1'b0;
    wait_idle(500, 0);
    dmin = 3; dmax = 3;
    run(32'hFFFF_FFFE, 1, 0);

    // randomized runs with stray starts mid-run
    repeat (6) begin
      p_rv  = $urandom_range(100, 50);
      p_taf = $urandom_range(20, 0);
      dmin  = 2;
      dmax  = $urandom_range(10, 2);
      run($urandom, $urandom_range(3, 1), 1);
    end
    repeat (3) step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
